// File: rtl/config_stream_loader.sv
// config_stream_loader: assembles little-endian (address, data) records from a
// valid/ready byte stream and presents each record on the shared tile config
// bus for exactly one clock cycle.
module config_stream_loader #(
   parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic [31:0]      config_addr,
   output logic [31:0]      config_data,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] records_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_ADDR, S_DATA, S_ISSUE, S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       byte_idx;
   logic [31:0]      shift_r;
   logic [31:0]      addr_r;
   logic [CNT_W-1:0] n_total;
   logic             xfer;
   logic             last_byte;
   logic             start_ok;
   logic [31:0]      word_nxt;

   assign xfer      = byte_valid && byte_ready;
   assign last_byte = xfer && (byte_idx == 2'd3);
   assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
   // Little-endian: each new byte enters at the top, so after four bytes the
   // first byte received sits in bits [7:0].
   assign word_nxt  = {byte_in, shift_r[31:8]};

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_COUNT;
         S_COUNT: if (last_byte)
                     state_nxt = (word_nxt[CNT_W-1:0] == '0) ? S_DONE : S_ADDR;
         S_ADDR:  if (last_byte) state_nxt = S_DATA;
         S_DATA:  if (last_byte) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = ((records_loaded + CNT_W'(1)) == n_total) ? S_DONE : S_ADDR;
         S_DONE:  if (start) state_nxt = S_COUNT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State-decoded handshake and status outputs
   always_comb begin
      byte_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_COUNT, S_ADDR, S_DATA: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
         S_ISSUE: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Byte assembly, record capture, registered bus drive and progress count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_idx       <= '0;
         shift_r        <= '0;
         addr_r         <= '0;
         n_total        <= '0;
         records_loaded <= '0;
         config_addr    <= IDLE_ADDR;
         config_data    <= '0;
      end else begin
         config_addr <= IDLE_ADDR;
         config_data <= '0;
         if (start_ok) begin
            records_loaded <= '0;
            byte_idx       <= '0;
            shift_r        <= '0;
         end
         if (xfer) begin
            shift_r  <= word_nxt;
            byte_idx <= byte_idx + 2'd1;
         end
         if (last_byte && (state == S_COUNT)) n_total <= word_nxt[CNT_W-1:0];
         if (last_byte && (state == S_ADDR))  addr_r  <= word_nxt;
         // Bus is loaded on the edge that enters ISSUE and falls back to idle on
         // the next edge, giving exactly one cycle of valid record.
         if (last_byte && (state == S_DATA)) begin
            config_addr <= addr_r;
            config_data <= word_nxt;
         end
         if (state == S_ISSUE) records_loaded <= records_loaded + CNT_W'(1);
      end
   end

endmodule
